alt_read_buffer: RTL

16-bit, DEPTH-entry buffer with one write port and two read ports. The read ports are served strictly alternately: port 1, then port 2, then port 1, and so on. It is the consumer-side counterpart of the alternating-write register. A single producer fills the buffer, and two downstream consumers take turns draining it in order, with no read/write conflicts.

---
 rtl/alt_rd_pkg.sv | 16 +
 rtl/alt_read_buffer_if.sv | 35 +++
 rtl/alt_rd_mem.sv | 29 ++
 rtl/alt_read_buffer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alt_rd_pkg.sv
// Shared definitions for the alternating-read buffer: default data width,
// turn encodings and pointer-width helper.
package alt_rd_pkg;

    localparam int unsigned WIDTH = 16;

    // Turn encodings for next_port
    localparam logic PORT_1 = 1'b0;
    localparam logic PORT_2 = 1'b1;

    // Width of a circular pointer into a depth-entry array (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/alt_read_buffer_if.sv
// Producer/consumer bus of the alternating-read buffer. The master side is the
// environment (producer and both consumers); the slave side is the buffer.
interface alt_read_buffer_if #(
    parameter int unsigned WIDTH = alt_rd_pkg::WIDTH,
    parameter int unsigned DEPTH = 4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en_1;
    logic             rd_en_2;
    logic [WIDTH-1:0] read_port_1;
    logic [WIDTH-1:0] read_port_2;
    logic             rd_valid_1;
    logic             rd_valid_2;
    logic             next_port;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output wr_en, wr_data, rd_en_1, rd_en_2,
        input  read_port_1, read_port_2, rd_valid_1, rd_valid_2,
        input  next_port, count, full, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en_1, rd_en_2,
        output read_port_1, read_port_2, rd_valid_1, rd_valid_2,
        output next_port, count, full, empty
    );

endinterface

// File: rtl/alt_rd_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port and one
// asynchronous read address. Contents are deliberately not reset.
module alt_rd_mem
    import alt_rd_pkg::*;
#(
    parameter int unsigned WIDTH = alt_rd_pkg::WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Load the addressed entry on an accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alt_read_buffer.sv
// Circular buffer with one write port and two read ports served strictly in
// turn (port 1, port 2, port 1, ...). Read data lands in a per-port register
// one cycle after an accepted request, flagged by a one-cycle rd_valid pulse.
module alt_read_buffer
    import alt_rd_pkg::*;
#(
    parameter int unsigned WIDTH = alt_rd_pkg::WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    alt_read_buffer_if.slave bus
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             turn_q, turn_d;
    logic [WIDTH-1:0] rp1_q, rp1_d;
    logic [WIDTH-1:0] rp2_q, rp2_d;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;

    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok_1;
    logic             rd_ok_2;
    logic             rd_ok;
    logic [WIDTH-1:0] mem_rdata;

    // Flags come straight from the registered count; no same-cycle bypass
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign wr_ok   = bus.wr_en && !full;
    assign rd_ok_1 = bus.rd_en_1 && (turn_q == PORT_1) && !empty;
    assign rd_ok_2 = bus.rd_en_2 && (turn_q == PORT_2) && !empty;
    assign rd_ok   = rd_ok_1 || rd_ok_2;

    alt_rd_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok && !rst),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state: pointers, occupancy, turn bit and per-port output registers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        turn_d   = turn_q;
        rp1_d    = rp1_q;
        rp2_d    = rp2_q;
        v1_d     = rd_ok_1;
        v2_d     = rd_ok_2;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            turn_d   = ~turn_q;
        end
        if (rd_ok_1) begin
            rp1_d = mem_rdata;
        end
        if (rd_ok_2) begin
            rp2_d = mem_rdata;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over any same-cycle request
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            turn_q   <= PORT_1;
            rp1_q    <= '0;
            rp2_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            turn_q   <= turn_d;
            rp1_q    <= rp1_d;
            rp2_q    <= rp2_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
        end
    end

    assign bus.read_port_1 = rp1_q;
    assign bus.read_port_2 = rp2_q;
    assign bus.rd_valid_1  = v1_q;
    assign bus.rd_valid_2  = v2_q;
    assign bus.next_port   = turn_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;

endmodule
